corescore_emitter_uart: RTL and testbench
=========================================

CORESCORE_EMITTER_UART -- requirements
Module: corescore_emitter_uart

Interface
REQ-001 SHALL have parameter clk_freq_hz, default 12000000: input clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 9600: serial bit rate in bit/s.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_data, input, 8 bits: byte to transmit.
REQ-006 SHALL have port i_valid, input, 1 bit: byte offer strobe.
REQ-007 SHALL have port o_ready, output, 1 bit: high when idle and able to accept a byte.
REQ-008 SHALL have port o_uart_tx, output, 1 bit: serial line, idle high.

Function
REQ-009 SHALL define CPB = clk_freq_hz / baud_rate using truncating integer division; each serial bit lasts exactly CPB clk cycles.
REQ-010 SHALL accept a byte on any rising edge where i_valid=1 and o_ready=1, latching i_data at that edge.
REQ-011 SHALL ignore i_valid while o_ready=0; i_data is not sampled and the frame in progress is unaffected.
REQ-012 SHALL drive o_ready low starting the cycle after the accept edge.
REQ-013 SHALL drive o_uart_tx low for the start bit starting the cycle after the accept edge (accept edge = N).
REQ-014 SHALL transmit 8N1: start bit 0, then data bits 0..7 LSB first, then one stop bit 1.
REQ-015 SHALL start data bit k at edge N+(k+1)*CPB and the stop bit at edge N+9*CPB.
REQ-016 SHALL raise o_ready at edge N+10*CPB; total frame time is 10*CPB cycles.
REQ-017 SHALL accept a new byte at edge N+10*CPB if i_valid=1 there; its start bit then follows the previous stop bit with no idle gap.
REQ-018 SHALL hold o_uart_tx=1 continuously while idle.
REQ-019 SHALL register o_uart_tx and o_ready directly from flops, with no combinational path from inputs.
REQ-020 SHALL hold the transmitted byte internally; changes on i_data after acceptance do not affect the frame.
REQ-021 SHALL size the bit-period counter as $clog2(CPB) bits (minimum 1) and the bit counter as 4 bits.
REQ-022 SHALL reject CPB < 2 at elaboration with a fatal error.

Reset
REQ-023 SHALL, while resetn=0 at a rising edge, set o_uart_tx=1, o_ready=1, all counters to 0 and the shift register to all ones.
REQ-024 SHALL abort a frame in progress when reset is asserted: the line goes high at the next edge and no partial bits resume after release.
REQ-025 SHALL not accept a byte at an edge where resetn=0, even if i_valid=1.
REQ-026 SHALL accept a byte at the first edge after release where i_valid=1.

Structure
REQ-027 SHALL compute CPB and the counter widths as localparams inside the module; no shared package is required.
REQ-028 SHALL, if split, use one sub-module uart_baud_gen: a CPB-cycle tick generator restarted on accept.
REQ-029 SHALL implement the datapath as a 10-bit shift register loaded with {1,data,0}, shifting right and inserting ones on each bit tick.
REQ-030 SHALL fit the implementation in 120-400 lines of RTL.

Verification
REQ-031 SHALL check, with clk_freq_hz=40 and baud_rate=10 (CPB=4): send 0x55 -> o_uart_tx 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; o_ready low for exactly 40 cycles.
REQ-032 SHALL check, with CPB=4: send 0x80 then hold i_valid with 0x01 -> frames 0,0000000,1,1 then 0,1,0000000,1 back-to-back with no idle cycle.
REQ-033 SHALL check, with CPB=4: pulse i_valid with 0xFF mid-frame while o_ready=0 -> byte dropped, current frame bit-exact, line idle after the stop bit.
REQ-034 SHALL check, with CPB=4: assert resetn=0 during data bit 3 -> next edge o_uart_tx=1 and o_ready=1; after release, send 0xA5 -> correct frame.
REQ-035 SHALL check, with default parameters (CPB=1250): send 0x41 -> start-bit width 1250 cycles and o_ready back high after 12500 cycles.
REQ-036 SHALL check, with clk_freq_hz=45 and baud_rate=10 (CPB=4 by truncation): send 0x00 -> each bit 4 cycles.

Source files
------------

// File: rtl/corescore_emitter_uart_pkg.sv
// Shared types and helpers for the 8N1 UART emitter; no logic, no latency.
package corescore_emitter_uart_pkg;

   typedef enum logic {
      ST_BUSY = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   localparam int         FRAME_BITS = 10;
   localparam logic [3:0] LAST_BIT   = 4'd9;

   // Line order is LSB first: start bit, data[0..7], stop bit.
   function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] data);
      return {1'b1, data, 1'b0};
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator: tick pulses every CPB cycles while enabled.
// restart zeroes the count so the first tick lands CPB cycles after it.
module uart_baud_gen #(
   parameter int CPB   = 4,
   parameter int CNT_W = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic restart,
   input  logic en,
   output logic tick
);

   logic [CNT_W-1:0] cnt;
   logic             at_end;

   assign at_end = (cnt == CNT_W'(CPB - 1));
   assign tick   = en && at_end;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (restart || !en || at_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/corescore_emitter_uart.sv
// 8N1 serial transmitter: byte accepted when ready, start bit the next cycle, frame lasts 10*CPB cycles.
// o_ready is low for the whole frame; a byte offered on the final edge chains with no idle gap.
module corescore_emitter_uart
   import corescore_emitter_uart_pkg::*;
#(
   parameter int clk_freq_hz = 12000000,
   parameter int baud_rate   = 9600
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_uart_tx
);

   localparam int CPB   = clk_freq_hz / baud_rate;
   localparam int CNT_W = (CPB < 2) ? 1 : $clog2(CPB);

   if (CPB < 2) begin : g_bad_cpb
      $fatal(1, "corescore_emitter_uart: clk_freq_hz/baud_rate must be at least 2");
   end

   state_t                state, state_nxt;
   logic [FRAME_BITS-1:0] shreg, shreg_nxt;
   logic [3:0]            bit_cnt, bit_cnt_nxt;
   logic                  accept;
   logic                  tick;

   uart_baud_gen #(
      .CPB   (CPB),
      .CNT_W (CNT_W)
   ) u_baud (
      .clk     (clk),
      .resetn  (resetn),
      .restart (accept),
      .en      (state == ST_BUSY),
      .tick    (tick)
   );

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      accept      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_valid) begin
               accept      = 1'b1;
               state_nxt   = ST_BUSY;
               shreg_nxt   = frame_word(i_data);
               bit_cnt_nxt = '0;
            end
         end
         ST_BUSY: begin
            if (tick) begin
               // The stop bit's final tick doubles as an accept slot so frames can abut.
               if (bit_cnt == LAST_BIT && i_valid) begin
                  accept      = 1'b1;
                  shreg_nxt   = frame_word(i_data);
                  bit_cnt_nxt = '0;
               end else if (bit_cnt == LAST_BIT) begin
                  state_nxt   = ST_IDLE;
                  shreg_nxt   = {1'b1, shreg[FRAME_BITS-1:1]};
                  bit_cnt_nxt = '0;
               end else begin
                  shreg_nxt   = {1'b1, shreg[FRAME_BITS-1:1]};
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         shreg   <= '1;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   assign o_uart_tx = shreg[0];
   assign o_ready   = (state == ST_IDLE);

endmodule

// File: tb/tb_corescore_emitter_uart.sv
// Bench for corescore_emitter_uart: three parameterisations driven with directed and random bytes,
// each line cycle compared against an 8N1 frame model built from the byte value.
module tb_corescore_emitter_uart;

   logic            clk;
   logic [2:0]      rstn;
   logic [2:0]      valid;
   logic [2:0][7:0] data;
   logic [2:0]      rdy;
   logic [2:0]      tx;

   int n_checks = 0;
   int n_fail   = 0;
   int cpb_of [3] = '{4, 1250, 4};

   corescore_emitter_uart #(.clk_freq_hz(40), .baud_rate(10)) dut_a (
      .clk(clk), .resetn(rstn[0]), .i_data(data[0]), .i_valid(valid[0]),
      .o_ready(rdy[0]), .o_uart_tx(tx[0]));

   corescore_emitter_uart dut_b (
      .clk(clk), .resetn(rstn[1]), .i_data(data[1]), .i_valid(valid[1]),
      .o_ready(rdy[1]), .o_uart_tx(tx[1]));

   corescore_emitter_uart #(.clk_freq_hz(45), .baud_rate(10)) dut_c (
      .clk(clk), .resetn(rstn[2]), .i_data(data[2]), .i_valid(valid[2]),
      .o_ready(rdy[2]), .o_uart_tx(tx[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Line level for bit slot idx of an 8N1 frame carrying b.
   function automatic logic line_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      return 1'b1;
   endfunction

   task automatic check_idle(input int inst);
      @(negedge clk);
      check($sformatf("idle%0d tx", inst), 32'(tx[inst]), 32'd1);
      check($sformatf("idle%0d rdy", inst), 32'(rdy[inst]), 32'd1);
   endtask

   // Present b and return right after the edge that accepts it (DUT known idle).
   task automatic offer(input int inst, input logic [7:0] b);
      valid[inst] = 1'b1;
      data[inst]  = b;
      @(posedge clk);
   endtask

   // Compare every cycle of the frame that started at the last edge.
   task automatic check_frame(input int inst, input logic [7:0] b, input logic nv,
                              input logic [7:0] nd, input int glitch_c, input int abort_c);
      int cpb = cpb_of[inst];
      for (int c = 0; c < 10 * cpb; c++) begin
         @(negedge clk);
         if (c == 0) begin
            valid[inst] = nv;
            data[inst]  = nd;
         end
         if (c == glitch_c) begin
            valid[inst] = 1'b1;
            data[inst]  = 8'hFF;
         end
         if (c == glitch_c + 1) valid[inst] = 1'b0;
         check($sformatf("frame%0d b%02h c%0d tx", inst, b, c), 32'(tx[inst]),
               32'(line_bit(b, c / cpb)));
         check($sformatf("frame%0d b%02h c%0d rdy", inst, b, c), 32'(rdy[inst]), 32'd0);
         if (c == abort_c) begin
            rstn[inst] = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      logic [7:0] b, nb;
      logic       chain;

      rstn  = 3'b000;
      valid = 3'b000;
      data  = '0;

      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) check_idle(i);
      rstn = 3'b111;
      for (int i = 0; i < 3; i++) check_idle(i);

      // 0x55 alternating pattern, CPB=4
      offer(0, 8'h55);
      check_frame(0, 8'h55, 1'b0, 8'h00, -10, -1);
      check_idle(0);

      // 0x80 then 0x01 held on i_valid: frames must abut
      offer(0, 8'h80);
      check_frame(0, 8'h80, 1'b1, 8'h01, -10, -1);
      check_frame(0, 8'h01, 1'b0, 8'h3C, -10, -1);
      check_idle(0);

      // 0xFF offered mid-frame while busy must be dropped
      b = 8'($urandom);
      offer(0, b);
      check_frame(0, b, 1'b0, 8'($urandom), 13, -1);
      check_idle(0);
      check_idle(0);

      // Reset during data bit 3 (slot 4, cycles 16..19), valid held through reset
      offer(0, 8'h3C);
      check_frame(0, 8'h3C, 1'b0, 8'h00, -10, 17);
      valid[0] = 1'b1;
      data[0]  = 8'hA5;
      @(negedge clk);
      check("rst_abort tx", 32'(tx[0]), 32'd1);
      check("rst_abort rdy", 32'(rdy[0]), 32'd1);
      @(negedge clk);
      check("rst_hold tx", 32'(tx[0]), 32'd1);
      check("rst_hold rdy", 32'(rdy[0]), 32'd1);
      rstn[0] = 1'b1;
      @(posedge clk);
      check_frame(0, 8'hA5, 1'b0, 8'h00, -10, -1);
      check_idle(0);

      // Random bytes with random chaining and gaps
      b = 8'($urandom);
      offer(0, b);
      for (int k = 0; k < 6; k++) begin
         chain = 1'($urandom_range(0, 1));
         nb    = 8'($urandom);
         check_frame(0, b, chain, nb, -10, -1);
         if (!chain) begin
            valid[0] = 1'b0;
            repeat ($urandom_range(1, 3)) check_idle(0);
            offer(0, nb);
         end
         b = nb;
      end
      check_frame(0, b, 1'b0, 8'h00, -10, -1);
      check_idle(0);

      // 45/10 truncates to CPB=4
      offer(2, 8'h00);
      check_frame(2, 8'h00, 1'b0, 8'h00, -10, -1);
      check_idle(2);

      // Default parameters, CPB=1250
      offer(1, 8'h41);
      check_frame(1, 8'h41, 1'b0, 8'h00, -10, -1);
      check_idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
